// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file writeback arbiter with pending-write scoreboard
module rf_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rg_wrt_en,
    output logic [4:0]      rg_wrt_addr,
    output logic [XLEN-1:0] rg_wrt_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [5:0]      pend_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic [5:0]  pend_cnt_nxt;
    logic [3:0]  starve_cnt;
    logic        starve_flag;
    logic        lsu_acc;
    logic        alu_acc;
    logic        iss_set;

    // Grant: LSU wins by default, a starved ALU takes the port once.
    // The two grants are mutually exclusive by construction.
    always_comb begin
        lsu_ready = !(starve_flag & alu_valid);
        alu_ready = !lsu_valid | starve_flag;
        lsu_acc   = lsu_valid & lsu_ready;
        alu_acc   = alu_valid & alu_ready;
    end

    // Hazard queries and next scoreboard contents; a same-edge set beats the clear.
    always_comb begin
        iss_ready = (iss_rd == 5'd0) | !pending[iss_rd];
        rs1_busy  = pending[rs1_addr];
        rs2_busy  = pending[rs2_addr];
        iss_set   = iss_valid & iss_ready & (iss_rd != 5'd0);
        pending_nxt = pending;
        if (rg_wrt_en) begin
            pending_nxt[rg_wrt_addr] = 1'b0;
        end
        if (iss_set) begin
            pending_nxt[iss_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
        pend_cnt_nxt = '0;
        for (int i = 0; i < 32; i++) begin
            pend_cnt_nxt = pend_cnt_nxt + 6'(pending_nxt[i]);
        end
    end

    // Registered write port; address and data hold when nothing is granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rg_wrt_en   <= 1'b0;
            rg_wrt_addr <= '0;
            rg_wrt_data <= '0;
        end else if (lsu_acc) begin
            rg_wrt_en   <= (lsu_rd != 5'd0);
            rg_wrt_addr <= lsu_rd;
            rg_wrt_data <= lsu_data;
        end else if (alu_acc) begin
            rg_wrt_en   <= (alu_rd != 5'd0);
            rg_wrt_addr <= alu_rd;
            rg_wrt_data <= alu_data;
        end else begin
            rg_wrt_en   <= 1'b0;
        end
    end

    // Pending-write scoreboard and its population count move together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pending_nxt;
            pend_cnt <= pend_cnt_nxt;
        end
    end

    // ALU starvation tracking; the flag arms on the edge the count hits the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt  <= '0;
            starve_flag <= 1'b0;
        end else if (!alu_valid) begin
            starve_cnt  <= '0;
        end else if (alu_acc) begin
            starve_cnt  <= '0;
            starve_flag <= 1'b0;
        end else begin
            if (starve_cnt < LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            if (starve_cnt + 4'd1 >= LIMIT) begin
                starve_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid, lsu_valid, iss_valid;
    logic            alu_ready, lsu_ready, iss_ready;
    logic [4:0]      alu_rd, lsu_rd, iss_rd, rs1_addr, rs2_addr;
    logic [XLEN-1:0] alu_data, lsu_data;
    logic            rg_wrt_en;
    logic [4:0]      rg_wrt_addr;
    logic [XLEN-1:0] rg_wrt_data;
    logic            rs1_busy, rs2_busy;
    logic [5:0]      pend_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit              m_pend [32];
    bit              m_wen;
    bit [4:0]        m_waddr;
    bit [XLEN-1:0]   m_wdata;
    int              m_starve;
    bit              m_starved;
    bit              last_aa, last_la;

    rf_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rg_wrt_en(rg_wrt_en), .rg_wrt_addr(rg_wrt_addr), .rg_wrt_data(rg_wrt_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_wen = 0; m_waddr = 0; m_wdata = 0; m_starve = 0; m_starved = 0;
        last_aa = 0; last_la = 0;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        iss_valid = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
    endtask

    // Advance one clock edge, updating the model from the inputs presented before it.
    task automatic tick();
        bit la, aa, dispatch;
        la = lsu_valid && !(m_starved && alu_valid);
        aa = alu_valid && (!lsu_valid || m_starved);
        dispatch = iss_valid && iss_rd != 0 && !m_pend[iss_rd];
        if (m_wen) m_pend[m_waddr] = 1'b0;
        if (dispatch) m_pend[iss_rd] = 1'b1;
        if (!alu_valid) m_starve = 0;
        else if (aa) begin m_starve = 0; m_starved = 0; end
        else begin
            if (m_starve < LIMIT) m_starve++;
            if (m_starve == LIMIT) m_starved = 1;
        end
        if (la) begin m_wen = (lsu_rd != 0); m_waddr = lsu_rd; m_wdata = lsu_data; end
        else if (aa) begin m_wen = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data; end
        else m_wen = 0;
        last_la = la; last_aa = aa;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rg_wrt_en, rg_wrt_addr, rg_wrt_data, pend_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got en=%0b addr=%0d data=%0h cnt=%0d required all zero",
                     rg_wrt_en, rg_wrt_addr, rg_wrt_data, pend_cnt);
        end
        reset = 1;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({rg_wrt_en, pend_cnt, alu_ready, lsu_ready} !== {1'b0, 6'd0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL reset_idle c%0d: got en=%0b cnt=%0d ar=%0b lr=%0b required 0 0 1 1",
                         c, rg_wrt_en, pend_cnt, alu_ready, lsu_ready);
            end
        end
    endtask

    task automatic test_single_alu();
        iss_valid = 1; iss_rd = 5; rs1_addr = 5;
        #1;
        checks++;
        if ({iss_ready, rs1_busy} !== 2'b10) begin
            errors++;
            $display("FAIL alu_issue: got iss_ready=%0b rs1_busy=%0b required 1 0", iss_ready, rs1_busy);
        end
        tick();
        iss_valid = 0; alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1;
        checks++;
        if ({rs1_busy, alu_ready, pend_cnt} !== {1'b1, 1'b1, 6'd1}) begin
            errors++;
            $display("FAIL alu_pending: got busy=%0b ar=%0b cnt=%0d required 1 1 1", rs1_busy, alu_ready, pend_cnt);
        end
        tick();
        alu_valid = 0;
        #1;
        checks++;
        if ({rg_wrt_en, rg_wrt_addr, rg_wrt_data, rs1_busy} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
            errors++;
            $display("FAIL alu_write: got en=%0b addr=%0d data=%0h busy=%0b required 1 5 deadbeef 1",
                     rg_wrt_en, rg_wrt_addr, rg_wrt_data, rs1_busy);
        end
        tick();
        checks++;
        if ({rs1_busy, pend_cnt, rg_wrt_en} !== {1'b0, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL alu_clear: got busy=%0b cnt=%0d en=%0b required 0 0 0", rs1_busy, pend_cnt, rg_wrt_en);
        end
    endtask

    task automatic test_collision();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h22;
        #1;
        checks++;
        if ({alu_ready, lsu_ready} !== 2'b01) begin
            errors++;
            $display("FAIL coll_ready: got ar=%0b lr=%0b required 0 1", alu_ready, lsu_ready);
        end
        tick();
        lsu_valid = 0;
        #1;
        checks++;
        if ({rg_wrt_en, rg_wrt_addr, rg_wrt_data} !== {1'b1, 5'd4, 32'h22}) begin
            errors++;
            $display("FAIL coll_lsu_first: got en=%0b addr=%0d data=%0h required 1 4 22", rg_wrt_en, rg_wrt_addr, rg_wrt_data);
        end
        tick();
        alu_valid = 0;
        #1;
        checks++;
        if ({rg_wrt_en, rg_wrt_addr, rg_wrt_data} !== {1'b1, 5'd3, 32'h11}) begin
            errors++;
            $display("FAIL coll_alu_next: got en=%0b addr=%0d data=%0h required 1 3 11", rg_wrt_en, rg_wrt_addr, rg_wrt_data);
        end
        tick();
        checks++;
        if (rg_wrt_en !== 1'b0) begin
            errors++;
            $display("FAIL coll_idle: got en=%0b required 0", rg_wrt_en);
        end
    endtask

    task automatic test_starvation();
        int j = 0;
        alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
        for (int i = 0; i < 10; i++) begin
            lsu_valid = 1; lsu_rd = 5'(10 + j); lsu_data = 32'(100 + j);
            #1;
            checks++;
            if ({alu_ready, lsu_ready} !== {i == 4, i != 4}) begin
                errors++;
                $display("FAIL starve_ready c%0d: got ar=%0b lr=%0b required %0b %0b",
                         i, alu_ready, lsu_ready, i == 4, i != 4);
            end
            tick();
            checks++;
            if (i == 4) begin
                if ({rg_wrt_en, rg_wrt_addr, rg_wrt_data} !== {1'b1, 5'd6, 32'h66}) begin
                    errors++;
                    $display("FAIL starve_alu_write: got en=%0b addr=%0d data=%0h required 1 6 66",
                             rg_wrt_en, rg_wrt_addr, rg_wrt_data);
                end
                alu_valid = 0;
            end else begin
                if ({rg_wrt_en, rg_wrt_addr, rg_wrt_data} !== {1'b1, 5'(10 + j), 32'(100 + j)}) begin
                    errors++;
                    $display("FAIL starve_lsu_write c%0d: got en=%0b addr=%0d data=%0h required 1 %0d %0h",
                             i, rg_wrt_en, rg_wrt_addr, rg_wrt_data, 10 + j, 100 + j);
                end
                j++;
            end
        end
        lsu_valid = 0;
        tick();
    endtask

    task automatic test_waw_x0();
        iss_valid = 1; iss_rd = 7; rs1_addr = 7;
        tick();
        #1;
        checks++;
        if ({iss_ready, rs1_busy, pend_cnt} !== {1'b0, 1'b1, 6'd1}) begin
            errors++;
            $display("FAIL waw_block: got iss_ready=%0b busy=%0b cnt=%0d required 0 1 1", iss_ready, rs1_busy, pend_cnt);
        end
        tick();
        iss_rd = 0;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_issue_ready: got %0b required 1", iss_ready);
        end
        tick();
        iss_valid = 0;
        checks++;
        if (pend_cnt !== 6'd1) begin
            errors++;
            $display("FAIL x0_cnt: got %0d required 1", pend_cnt);
        end
        alu_valid = 1; alu_rd = 0; alu_data = 32'hABC;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_alu_ready: got %0b required 1", alu_ready);
        end
        tick();
        alu_valid = 0;
        checks++;
        if ({rg_wrt_en, rg_wrt_addr, rg_wrt_data, pend_cnt} !== {1'b0, 5'd0, 32'hABC, 6'd1}) begin
            errors++;
            $display("FAIL x0_write: got en=%0b addr=%0d data=%0h cnt=%0d required 0 0 abc 1",
                     rg_wrt_en, rg_wrt_addr, rg_wrt_data, pend_cnt);
        end
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        tick();
        alu_valid = 0;
        tick();
        checks++;
        if (pend_cnt !== 6'd0) begin
            errors++;
            $display("FAIL waw_cleanup: got cnt=%0d required 0", pend_cnt);
        end
    endtask

    task automatic test_reset_mid();
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99; rs1_addr = 9;
        tick();
        lsu_valid = 0; iss_valid = 1; iss_rd = 9;
        #1;
        checks++;
        if ({rg_wrt_en, rg_wrt_addr, iss_ready} !== {1'b1, 5'd9, 1'b1}) begin
            errors++;
            $display("FAIL setclr_pre: got en=%0b addr=%0d iss_ready=%0b required 1 9 1", rg_wrt_en, rg_wrt_addr, iss_ready);
        end
        tick();
        iss_valid = 0;
        checks++;
        if ({rs1_busy, pend_cnt} !== {1'b1, 6'd1}) begin
            errors++;
            $display("FAIL setclr_set_wins: got busy=%0b cnt=%0d required 1 1", rs1_busy, pend_cnt);
        end
        alu_valid = 1; alu_rd = 12; alu_data = 32'h1234;
        tick();
        alu_valid = 0;
        reset = 0;
        #1;
        checks++;
        if ({rg_wrt_en, pend_cnt, rs1_busy} !== {1'b0, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got en=%0b cnt=%0d busy=%0b required 0 0 0", rg_wrt_en, pend_cnt, rs1_busy);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        model_reset();
        reset = 1;
        tick();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            if (!alu_valid || last_aa) begin
                alu_valid = 1'($urandom_range(0, 1)); alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
            end
            if (!lsu_valid || last_la) begin
                lsu_valid = 1'($urandom_range(0, 1)); lsu_rd = 5'($urandom_range(0, 7)); lsu_data = $urandom;
            end
            iss_valid = 1'($urandom_range(0, 1)); iss_rd = 5'($urandom_range(0, 7));
            rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if ({alu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy} !==
                {!lsu_valid || m_starved, !(m_starved && alu_valid), iss_rd == 0 || !m_pend[iss_rd],
                 m_pend[rs1_addr], m_pend[rs2_addr]}) begin
                errors++;
                $display("FAIL rand_comb c%0d: got ar=%0b lr=%0b ir=%0b b1=%0b b2=%0b required %0b %0b %0b %0b %0b",
                         c, alu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
                         !lsu_valid || m_starved, !(m_starved && alu_valid), iss_rd == 0 || !m_pend[iss_rd],
                         m_pend[rs1_addr], m_pend[rs2_addr]);
            end
            tick();
            checks++;
            if ({rg_wrt_en, rg_wrt_addr, rg_wrt_data, pend_cnt} !== {m_wen, m_waddr, m_wdata, 6'(m_count())}) begin
                errors++;
                $display("FAIL rand_reg c%0d: got en=%0b addr=%0d data=%0h cnt=%0d required %0b %0d %0h %0d",
                         c, rg_wrt_en, rg_wrt_addr, rg_wrt_data, pend_cnt, m_wen, m_waddr, m_wdata, m_count());
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_collision();
        test_starvation();
        test_waw_x0();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: the ALU (single-cycle results) and the LSU (load data).
- Drives the register file's write enable, write address and write data from registered outputs.
- Keeps a per-register pending scoreboard so decode/issue can stall on RAW and WAW hazards.
- Sits between the execute/memory units and the register file; the issue logic queries it every cycle.

Parameters:
- XLEN, 32, data width of writeback data.
- STARVE_LIMIT, 4, consecutive cycles the ALU is refused before it is forced priority (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle when alu_valid is also high.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  LSU writeback request.
- lsu_ready  out  1  LSU request accepted this cycle when lsu_valid is also high.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  XLEN  load data.
- rg_wrt_en  out  1  register-file write enable (registered).
- rg_wrt_addr  out  5  register-file write address (registered).
- rg_wrt_data  out  XLEN  register-file write data (registered).
- iss_valid  in  1  issue stage dispatching an instruction that writes iss_rd.
- iss_rd  in  5  destination of the dispatching instruction.
- iss_ready  out  1  dispatch allowed (no WAW on iss_rd).
- rs1_addr  in  5  source-1 hazard query.
- rs2_addr  in  5  source-2 hazard query.
- rs1_busy  out  1  pending[rs1_addr], combinational.
- rs2_busy  out  1  pending[rs2_addr], combinational.
- pend_cnt  out  6  number of set pending bits (0..31).

Behaviour:
- Reset (reset=0, asynchronous): rg_wrt_en=0, rg_wrt_addr=0, rg_wrt_data=0, pending=0, pend_cnt=0, starve_cnt=0, starve_flag=0. Outputs hold these values until the first rising edge after reset is released.
- Ready is independent of the requester's own valid:
  - lsu_ready = !(starve_flag & alu_valid).
  - alu_ready = !lsu_valid | starve_flag.
- At most one requester is accepted per cycle. Default priority is LSU over ALU.
- Accept means valid & ready at a rising edge.
- On accept, at that edge:
  - rg_wrt_en <= (rd != 0).
  - rg_wrt_addr <= rd.
  - rg_wrt_data <= data.
- Latency is 1 cycle from accept to rg_wrt_en high. The register file commits the write on the following edge.
- No accept: rg_wrt_en <= 0. rg_wrt_addr and rg_wrt_data hold their previous values.
- rd=0 is accepted and consumed, but produces rg_wrt_en=0 and no scoreboard change.
- Starvation control:
  - Each cycle with alu_valid & !alu_ready: starve_cnt increments, saturating at STARVE_LIMIT.
  - When starve_cnt reaches STARVE_LIMIT, starve_flag <= 1.
  - On ALU accept, starve_cnt <= 0 and starve_flag <= 0.
  - alu_valid low clears starve_cnt, but does not clear an already-set starve_flag.
- Requesters must hold valid, rd and data stable until accepted. Behaviour under violation is undefined.
- Scoreboard pending[31:0]: pending[0] is always 0.
  - Set: at the edge where iss_valid & iss_ready & iss_rd != 0.
  - Clear: at the edge where rg_wrt_en=1, for bit rg_wrt_addr. This is the same edge the register file writes.
  - Same register set and cleared at the same edge: set wins, so the bit stays 1.
- iss_ready = (iss_rd == 0) | !pending[iss_rd], computed combinationally.
- Writeback to a register that is not pending is legal: the write happens and the bit stays 0.
- pend_cnt is registered and updated together with pending. It equals the popcount of pending after every edge.
- rs1_busy and rs2_busy use the current pending contents. There is no bypass: a bit clears on the write edge, so the register-file read in the next cycle returns the new value.
- Reset asserted mid-operation: an in-flight registered write is dropped (rg_wrt_en=0 immediately). All pending bits clear. Requesters must re-present their requests after reset.

Test Plan:
1. Reset then idle: hold reset=0 for 3 cycles, release, no requests for 5 cycles -> rg_wrt_en=0, pend_cnt=0, alu_ready=1, lsu_ready=1 throughout.
2. Single ALU write: issue iss_rd=5, next cycle alu_valid with rd=5, data=0xDEADBEEF -> alu_ready=1, next cycle rg_wrt_en=1, addr=5, data=0xDEADBEEF; rs1_busy for 5 is 1 until that edge, then 0; pend_cnt goes 1 -> 0.
3. Collision: alu (rd=3, 0x11) and lsu (rd=4, 0x22) valid in the same cycle -> LSU written first (addr 4, 0x22), ALU written next cycle (addr 3, 0x11); exactly one rg_wrt_en pulse per cycle.
4. Starvation with STARVE_LIMIT=4: lsu_valid held high for 10 cycles (a new rd each time) with alu_valid held high -> ALU refused 4 cycles, then alu_ready=1 and lsu_ready=0 for exactly one cycle, ALU written, LSU resumes.
5. WAW and x0: pending[7] set, iss_rd=7 -> iss_ready=0; iss_rd=0 -> iss_ready=1 with pend_cnt unchanged; alu rd=0 accepted -> rg_wrt_en stays 0.
6. Reset mid-write plus set/clear collision: pending[9] set, write to 9 in progress while iss dispatches rd=9 at the write edge -> pending[9] remains 1; then assert reset between accept and write -> rg_wrt_en=0 immediately, pend_cnt=0.
